// File: rtl/router_sync_ctrl_pkg.sv
// Shared address encoding, default timeout and one-hot decode for the router sync block.
package router_pkg;

    typedef enum logic [1:0] {
        ADDR_P0      = 2'b00,
        ADDR_P1      = 2'b01,
        ADDR_P2      = 2'b10,
        ADDR_INVALID = 2'b11
    } addr_e;

    localparam int DEF_TIMEOUT = 30;

    function automatic logic [2:0] onehot(input addr_e addr);
        case (addr)
            ADDR_P0: return 3'b001;
            ADDR_P1: return 3'b010;
            ADDR_P2: return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/router_sync_ctrl_if.sv
// FSM/FIFO-side signal bundle of router_sync_ctrl; drop_cnt_x exists only with ROUTER_SYNC_STATS_EN.
interface router_sync_ctrl_if #(
    parameter int STAT_W = 8
);
    logic       detect_add;
    logic [1:0] data_in;
    logic       write_enb_reg;
    logic       full_0, full_1, full_2;
    logic       empty_0, empty_1, empty_2;
    logic       read_enb_0, read_enb_1, read_enb_2;
    logic [2:0] write_enb;
    logic       fifo_full;
    logic       vld_out_0, vld_out_1, vld_out_2;
    logic       soft_reset_0, soft_reset_1, soft_reset_2;
`ifdef ROUTER_SYNC_STATS_EN
    logic [STAT_W-1:0] drop_cnt_0, drop_cnt_1, drop_cnt_2;
`endif

    modport master (
        output detect_add, data_in, write_enb_reg,
        output full_0, full_1, full_2, empty_0, empty_1, empty_2,
        output read_enb_0, read_enb_1, read_enb_2,
        input  write_enb, fifo_full, vld_out_0, vld_out_1, vld_out_2,
`ifdef ROUTER_SYNC_STATS_EN
        input  drop_cnt_0, drop_cnt_1, drop_cnt_2,
`endif
        input  soft_reset_0, soft_reset_1, soft_reset_2
    );

    modport slave (
        input  detect_add, data_in, write_enb_reg,
        input  full_0, full_1, full_2, empty_0, empty_1, empty_2,
        input  read_enb_0, read_enb_1, read_enb_2,
        output write_enb, fifo_full, vld_out_0, vld_out_1, vld_out_2,
`ifdef ROUTER_SYNC_STATS_EN
        output drop_cnt_0, drop_cnt_1, drop_cnt_2,
`endif
        output soft_reset_0, soft_reset_1, soft_reset_2
    );

endinterface

// File: rtl/router_sync_ctrl_timer.sv
// Per-port idle timeout: pulses soft_reset after TIMEOUT valid-but-unread cycles.
// Optional saturating drop counter when ROUTER_SYNC_STATS_EN is defined.
module router_sync_timer #(
    parameter int TIMEOUT = 30,
    parameter int CNT_W   = 5,
    parameter int STAT_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              empty,
    input  logic              read_enb,
`ifdef ROUTER_SYNC_STATS_EN
    output logic [STAT_W-1:0] drop_cnt,
`endif
    output logic              soft_reset
);

    logic [CNT_W-1:0] cnt;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt        <= '0;
            soft_reset <= 1'b0;
        end else if (empty || read_enb) begin
            cnt        <= '0;
            soft_reset <= 1'b0;
        end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            cnt        <= '0;
            soft_reset <= 1'b1;
        end else begin
            cnt        <= cnt + CNT_W'(1);
            soft_reset <= 1'b0;
        end
    end

`ifdef ROUTER_SYNC_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            drop_cnt <= '0;
        end else if (soft_reset && (drop_cnt != '1)) begin
            drop_cnt <= drop_cnt + STAT_W'(1);
        end
    end
`endif

endmodule

// File: rtl/router_sync_ctrl.sv
// Address latch, write-enable decode, full mux and three idle timers for the 1x3 router.
// Build option: ROUTER_SYNC_STATS_EN adds per-port timeout drop counters.
module router_sync_ctrl
    import router_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT,
    parameter int CNT_W   = 5,
    parameter int STAT_W  = 8
) (
    input  logic               clk,
    input  logic               reset,
    router_sync_ctrl_if.slave  bus
);

    addr_e      addr_q;
    logic [2:0] we;
    logic       ff;
    logic [2:0] empty_v, read_v, soft_v, full_v;

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q <= ADDR_INVALID;
        end else if (bus.detect_add) begin
            addr_q <= addr_e'(bus.data_in);
        end
    end

    assign full_v  = {bus.full_2, bus.full_1, bus.full_0};
    assign empty_v = {bus.empty_2, bus.empty_1, bus.empty_0};
    assign read_v  = {bus.read_enb_2, bus.read_enb_1, bus.read_enb_0};

    // NOTE: defaults first, so no path through this block leaves an output unassigned (no latch).
    always_comb begin
        we = 3'b000;
        ff = 1'b0;
        if (bus.write_enb_reg) begin
            we = onehot(addr_q);
        end
        if (addr_q != ADDR_INVALID) begin
            ff = full_v[addr_q];
        end
    end

    assign bus.write_enb = we;
    assign bus.fifo_full = ff;
    assign bus.vld_out_0 = ~bus.empty_0;
    assign bus.vld_out_1 = ~bus.empty_1;
    assign bus.vld_out_2 = ~bus.empty_2;

`ifdef ROUTER_SYNC_STATS_EN
    logic [STAT_W-1:0] drop_v [3];
`endif

    for (genvar i = 0; i < 3; i++) begin : g_timer
        router_sync_timer #(
            .TIMEOUT (TIMEOUT),
            .CNT_W   (CNT_W),
            .STAT_W  (STAT_W)
        ) u_timer (
            .clk        (clk),
            .reset      (reset),
            .empty      (empty_v[i]),
            .read_enb   (read_v[i]),
`ifdef ROUTER_SYNC_STATS_EN
            .drop_cnt   (drop_v[i]),
`endif
            .soft_reset (soft_v[i])
        );
    end

    assign bus.soft_reset_0 = soft_v[0];
    assign bus.soft_reset_1 = soft_v[1];
    assign bus.soft_reset_2 = soft_v[2];

`ifdef ROUTER_SYNC_STATS_EN
    assign bus.drop_cnt_0 = drop_v[0];
    assign bus.drop_cnt_1 = drop_v[1];
    assign bus.drop_cnt_2 = drop_v[2];
`endif

endmodule

// File: tb/tb_router_sync_ctrl.sv
// Directed bench for router_sync_ctrl: vector table for decode/mux, sequences for timeouts.
// Define ROUTER_SYNC_STATS_EN to also exercise the drop counters.
module tb_router_sync_ctrl;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    router_sync_ctrl_if #(.STAT_W(8)) bus ();

    router_sync_ctrl #(.TIMEOUT(30), .CNT_W(5), .STAT_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       det;
        logic [1:0] data;
        logic       wer;
        logic [2:0] full;
        logic [2:0] empty;
        logic [2:0] exp_we;
        logic       exp_ff;
        logic [2:0] exp_vld;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [2:0] soft_vec();
        return {bus.soft_reset_2, bus.soft_reset_1, bus.soft_reset_0};
    endfunction

    function automatic logic [2:0] vld_vec();
        return {bus.vld_out_2, bus.vld_out_1, bus.vld_out_0};
    endfunction

    task automatic set_empty(input logic [2:0] e);
        {bus.empty_2, bus.empty_1, bus.empty_0} = e;
    endtask

    task automatic set_full(input logic [2:0] f);
        {bus.full_2, bus.full_1, bus.full_0} = f;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic idle_steps(input int n, input string tag);
        for (int k = 0; k < n; k++) begin
            step();
            check($sformatf("%s_quiet_%0d", tag, k + 1), {29'd0, soft_vec()}, 32'd0);
        end
    endtask

    // Expects the pulse on the n-th edge from now, on port p only, then low again.
    task automatic wait_pulse(input int p, input int n, input string tag);
        idle_steps(n - 1, tag);
        step();
        check($sformatf("%s_pulse", tag), {29'd0, soft_vec()}, 32'(1 << p));
        step();
        check($sformatf("%s_after", tag), {29'd0, soft_vec()}, 32'd0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        bus.detect_add    = 1'b0;
        bus.data_in       = 2'b00;
        bus.write_enb_reg = 1'b0;
        bus.read_enb_0    = 1'b0;
        bus.read_enb_1    = 1'b0;
        bus.read_enb_2    = 1'b0;
        set_full(3'b000);
        set_empty(3'b101);

        // Reset state; vld_out tracks empty even while reset is held.
        step();
        step();
        bus.write_enb_reg = 1'b1;
        set_full(3'b111);
        #1;
        check("rst_write_enb", {29'd0, bus.write_enb}, 32'd0);
        check("rst_fifo_full", {31'd0, bus.fifo_full}, 32'd0);
        check("rst_vld", {29'd0, vld_vec()}, 32'b010);
        check("rst_soft", {29'd0, soft_vec()}, 32'd0);
        bus.write_enb_reg = 1'b0;
        set_empty(3'b111);
        reset = 1'b0;

        //               det  data   wer   full    empty   exp_we  ff    vld
        vecs[0]  = '{1'b0, 2'b00, 1'b1, 3'b111, 3'b111, 3'b000, 1'b0, 3'b000};
        vecs[1]  = '{1'b1, 2'b01, 1'b0, 3'b000, 3'b110, 3'b000, 1'b0, 3'b001};
        vecs[2]  = '{1'b0, 2'b00, 1'b1, 3'b000, 3'b101, 3'b010, 1'b0, 3'b010};
        vecs[3]  = '{1'b0, 2'b00, 1'b1, 3'b010, 3'b011, 3'b010, 1'b1, 3'b100};
        vecs[4]  = '{1'b0, 2'b00, 1'b1, 3'b101, 3'b111, 3'b010, 1'b0, 3'b000};
        vecs[5]  = '{1'b1, 2'b10, 1'b1, 3'b000, 3'b111, 3'b010, 1'b0, 3'b000};
        vecs[6]  = '{1'b0, 2'b00, 1'b1, 3'b100, 3'b111, 3'b100, 1'b1, 3'b000};
        vecs[7]  = '{1'b1, 2'b11, 1'b1, 3'b011, 3'b111, 3'b100, 1'b0, 3'b000};
        vecs[8]  = '{1'b0, 2'b00, 1'b1, 3'b111, 3'b111, 3'b000, 1'b0, 3'b000};
        vecs[9]  = '{1'b1, 2'b00, 1'b0, 3'b111, 3'b000, 3'b000, 1'b0, 3'b111};
        vecs[10] = '{1'b0, 2'b00, 1'b1, 3'b001, 3'b111, 3'b001, 1'b1, 3'b000};
        vecs[11] = '{1'b0, 2'b00, 1'b0, 3'b001, 3'b111, 3'b000, 1'b1, 3'b000};

        for (int i = 0; i < 12; i++) begin
            bus.detect_add    = vecs[i].det;
            bus.data_in       = vecs[i].data;
            bus.write_enb_reg = vecs[i].wer;
            set_full(vecs[i].full);
            set_empty(vecs[i].empty);
            #1;
            check($sformatf("vec%0d_write_enb", i), {29'd0, bus.write_enb}, {29'd0, vecs[i].exp_we});
            check($sformatf("vec%0d_fifo_full", i), {31'd0, bus.fifo_full}, {31'd0, vecs[i].exp_ff});
            check($sformatf("vec%0d_vld", i), {29'd0, vld_vec()}, {29'd0, vecs[i].exp_vld});
            step();
        end
        bus.detect_add    = 1'b0;
        bus.write_enb_reg = 1'b0;
        set_full(3'b000);
        set_empty(3'b111);

        // Port 2 held valid and unread: pulses at edge 30, then again at edge 60.
        do_reset();
        set_empty(3'b011);
        wait_pulse(2, 30, "to2_first");
        wait_pulse(2, 29, "to2_second");

        // Read on idle cycle 29 cancels; next pulse comes 30 idle cycles after the read.
        set_empty(3'b111);
        do_reset();
        set_empty(3'b011);
        idle_steps(28, "rd29_pre");
        bus.read_enb_2 = 1'b1;
        step();
        check("rd29_no_pulse", {29'd0, soft_vec()}, 32'd0);
        bus.read_enb_2 = 1'b0;
        wait_pulse(2, 30, "rd29_next");

        // Reset at idle cycle 20: no pulse, address back to invalid, fresh count after.
        set_empty(3'b111);
        do_reset();
        set_empty(3'b011);
        bus.detect_add = 1'b1;
        bus.data_in    = 2'b01;
        step();
        bus.detect_add = 1'b0;
        idle_steps(19, "midrst_pre");
        reset = 1'b1;
        step();
        bus.write_enb_reg = 1'b1;
        #1;
        check("midrst_soft", {29'd0, soft_vec()}, 32'd0);
        check("midrst_addr_invalid", {29'd0, bus.write_enb}, 32'd0);
        check("midrst_vld", {29'd0, vld_vec()}, 32'b100);
        bus.write_enb_reg = 1'b0;
        reset = 1'b0;
        wait_pulse(2, 30, "midrst_post");

        // Ports 0 and 1 time out on the same edge.
        set_empty(3'b111);
        do_reset();
        set_empty(3'b100);
        idle_steps(29, "dual_pre");
        step();
        check("dual_pulse", {29'd0, soft_vec()}, 32'b011);
        step();
        check("dual_after", {29'd0, soft_vec()}, 32'd0);

`ifdef ROUTER_SYNC_STATS_EN
        set_empty(3'b111);
        do_reset();
        check("drop_rst_0", 32'(bus.drop_cnt_0), 32'd0);
        set_empty(3'b110);
        repeat (91) step();
        check("drop3_port0", 32'(bus.drop_cnt_0), 32'd3);
        check("drop3_port1", 32'(bus.drop_cnt_1), 32'd0);
        check("drop3_port2", 32'(bus.drop_cnt_2), 32'd0);
        repeat (260 * 30) step();
        check("drop_sat_port0", 32'(bus.drop_cnt_0), 32'd255);
        check("drop_sat_port1", 32'(bus.drop_cnt_1), 32'd0);
        do_reset();
        check("drop_clear_port0", 32'(bus.drop_cnt_0), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
